decode: RTL and testbench

- Decode stage directly downstream of the fetch stage in the asynchronous ARM pipeline.
- Accepts a 32-bit instruction word and its PC+4 value over a two-phase toggle handshake, using bundled data.
- Synchronises the handshake into one clock domain, buffers one word, decodes ARM fields into registered outputs, and presents them to execute over a second two-phase toggle handshake.

---
 rtl/decode_pkg.sv | 37 +++
 rtl/decode_toggle_sync.sv | 28 ++
 rtl/decode.sv | 146 ++++++++++++++
 tb/tb_decode.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the ARM decode stage: instruction classes, field
// positions, output-stage FSM states and the DP immediate rotator.
package decode_pkg;

  typedef enum logic [2:0] {
    CLASS_DP_REG = 3'd0,
    CLASS_DP_IMM = 3'd1,
    CLASS_LDST   = 3'd2,
    CLASS_BRANCH = 3'd3,
    CLASS_MUL    = 3'd4,
    CLASS_SWI    = 3'd5,
    CLASS_UNDEF  = 3'd7
  } instr_class_t;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    HOLD
  } state_t;

  localparam int unsigned COND_LSB   = 28;
  localparam int unsigned OPCODE_LSB = 21;
  localparam int unsigned LINK_BIT   = 24;
  localparam int unsigned S_BIT      = 20;
  localparam int unsigned RN_LSB     = 16;
  localparam int unsigned RD_LSB     = 12;
  localparam int unsigned RS_LSB     = 8;
  localparam int unsigned RM_LSB     = 0;

  // imm8 rotated right by 2*rot, done as a shift of a doubled word.
  function automatic logic [31:0] ror_imm(input logic [7:0] imm8, input logic [3:0] rot);
    logic [63:0] wide;
    wide = {24'd0, imm8, 24'd0, imm8} >> {rot, 1'b0};
    return wide[31:0];
  endfunction

endpackage

// File: rtl/decode_toggle_sync.sv
// Two-phase toggle receiver: synchroniser chain plus phase-seen register;
// pending stays high until the consumer acknowledges with consume.
module toggle_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic toggle,
  input  logic consume,
  output logic pending
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   phase_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync       <= '0;
      phase_seen <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], toggle};
      if (consume) phase_seen <= ~phase_seen;
    end
  end

  assign pending = sync[SYNC_STAGES-1] ^ phase_seen;

endmodule

// File: rtl/decode.sv
// ARM decode stage: toggle-handshake capture into a one-word buffer, field
// decode, and registered presentation to execute over a second handshake.
module decode
  import decode_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              triggerIn,
  input  logic [31:0]       dataIn,
  input  logic [ADDR_W-1:0] pcIn,
  output logic              readyOut,
  output logic              triggerOut,
  input  logic              readyIn,
  output logic [3:0]        condOut,
  output logic [2:0]        classOut,
  output logic [3:0]        opcodeOut,
  output logic              setFlagsOut,
  output logic [3:0]        rnOut,
  output logic [3:0]        rdOut,
  output logic [3:0]        rmOut,
  output logic [31:0]       immOut,
  output logic              linkOut,
  output logic [ADDR_W-1:0] branchTargetOut,
  output logic [ADDR_W-1:0] pcOut
);

  state_t              state;
  logic                req_pending, ack_pending, capture, ack_take;
  logic                buf_valid;
  logic [31:0]         buf_data;
  logic [ADDR_W-1:0]   buf_pc;

  instr_class_t        dec_class;
  logic [3:0]          dec_opcode, dec_rn, dec_rd, dec_rm;
  logic                dec_s, dec_link;
  logic [31:0]         dec_imm;
  logic signed [25:0]  br_off;
  logic [ADDR_W-1:0]   dec_target;

  // A word being drained in DECODE frees the buffer on the same edge.
  assign capture  = req_pending && (!buf_valid || state == DECODE);
  assign ack_take = ack_pending && state == HOLD;

  toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .clk(clk), .rst(rst), .toggle(triggerIn), .consume(capture), .pending(req_pending)
  );

  toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk(clk), .rst(rst), .toggle(readyIn), .consume(ack_take), .pending(ack_pending)
  );

  always_comb begin
    dec_class  = CLASS_UNDEF;
    dec_opcode = '0;
    dec_s      = 1'b0;
    dec_rn     = '0;
    dec_rd     = '0;
    dec_rm     = '0;
    dec_imm    = '0;
    dec_link   = 1'b0;
    if (buf_data[27:22] == 6'b000000 && buf_data[7:4] == 4'b1001) dec_class = CLASS_MUL;
    else if (buf_data[27:26] == 2'b00) dec_class = buf_data[25] ? CLASS_DP_IMM : CLASS_DP_REG;
    else if (buf_data[27:26] == 2'b01) dec_class = CLASS_LDST;
    else if (buf_data[27:25] == 3'b101) dec_class = CLASS_BRANCH;
    else if (buf_data[27:24] == 4'hF) dec_class = CLASS_SWI;
    if (dec_class != CLASS_UNDEF) begin
      dec_rn = buf_data[RN_LSB +: 4];
      dec_rd = buf_data[RD_LSB +: 4];
      dec_rm = buf_data[RM_LSB +: 4];
    end
    case (dec_class)
      CLASS_DP_REG, CLASS_DP_IMM: begin
        dec_opcode = buf_data[OPCODE_LSB +: 4];
        dec_s      = buf_data[S_BIT];
        if (dec_class == CLASS_DP_IMM) dec_imm = ror_imm(buf_data[7:0], buf_data[11:8]);
      end
      CLASS_LDST:   dec_imm  = {20'd0, buf_data[11:0]};
      CLASS_BRANCH: dec_link = buf_data[LINK_BIT];
      CLASS_MUL: begin
        dec_s  = buf_data[S_BIT];
        dec_rd = buf_data[RN_LSB +: 4];
        dec_rn = buf_data[RS_LSB +: 4];
      end
      CLASS_SWI:    dec_imm  = {8'd0, buf_data[23:0]};
      default: ;
    endcase
  end

  assign br_off     = {buf_data[23:0], 2'b00};
  assign dec_target = buf_pc + ADDR_W'(4) + ADDR_W'(br_off);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      buf_valid       <= 1'b0;
      buf_data        <= '0;
      buf_pc          <= '0;
      readyOut        <= 1'b0;
      triggerOut      <= 1'b0;
      condOut         <= '0;
      classOut        <= '0;
      opcodeOut       <= '0;
      setFlagsOut     <= 1'b0;
      rnOut           <= '0;
      rdOut           <= '0;
      rmOut           <= '0;
      immOut          <= '0;
      linkOut         <= 1'b0;
      branchTargetOut <= '0;
      pcOut           <= '0;
    end else begin
      if (capture) begin
        buf_data  <= dataIn;
        buf_pc    <= pcIn;
        readyOut  <= ~readyOut;
        buf_valid <= 1'b1;
      end else if (state == DECODE) begin
        buf_valid <= 1'b0;
      end
      case (state)
        IDLE: if (buf_valid) state <= DECODE;
        DECODE: begin
          condOut         <= buf_data[COND_LSB +: 4];
          classOut        <= dec_class;
          opcodeOut       <= dec_opcode;
          setFlagsOut     <= dec_s;
          rnOut           <= dec_rn;
          rdOut           <= dec_rd;
          rmOut           <= dec_rm;
          immOut          <= dec_imm;
          linkOut         <= dec_link;
          branchTargetOut <= dec_target;
          pcOut           <= buf_pc;
          triggerOut      <= ~triggerOut;
          state           <= HOLD;
        end
        HOLD: if (ack_take) state <= (buf_valid || capture) ? DECODE : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode stage: handshakes, latency, field decode,
// buffer-full back-pressure and mid-operation reset.
module tb_decode;
  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              triggerIn = 1'b0;
  logic [31:0]       dataIn = '0;
  logic [ADDR_W-1:0] pcIn = '0;
  logic              readyOut, triggerOut;
  logic              readyIn = 1'b0;
  logic [3:0]        condOut, opcodeOut, rnOut, rdOut, rmOut;
  logic [2:0]        classOut;
  logic              setFlagsOut, linkOut;
  logic [31:0]       immOut;
  logic [ADDR_W-1:0] branchTargetOut, pcOut;

  int   compared = 0;
  int   mismatched = 0;
  logic exp_ready = 1'b0;
  logic exp_trig = 1'b0;

  always #5 clk = ~clk;

  decode #(.SYNC_STAGES(2), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .triggerIn(triggerIn), .dataIn(dataIn), .pcIn(pcIn),
    .readyOut(readyOut), .triggerOut(triggerOut), .readyIn(readyIn),
    .condOut(condOut), .classOut(classOut), .opcodeOut(opcodeOut),
    .setFlagsOut(setFlagsOut), .rnOut(rnOut), .rdOut(rdOut), .rmOut(rmOut),
    .immOut(immOut), .linkOut(linkOut), .branchTargetOut(branchTargetOut), .pcOut(pcOut)
  );

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (readyOut === exp_ready) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_trig(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (triggerOut === exp_trig) begin ok = 1'b1; break; end
    end
  endtask

  task automatic put_word(input logic [31:0] d, input logic [ADDR_W-1:0] p);
    @(negedge clk);
    dataIn = d;
    pcIn = p;
    triggerIn = ~triggerIn;
  endtask

  task automatic send_and_decode(input logic [31:0] d, input logic [ADDR_W-1:0] p, output bit ok);
    bit ok_r, ok_t;
    put_word(d, p);
    exp_ready = ~exp_ready;
    wait_ready(ok_r);
    exp_trig = ~exp_trig;
    wait_trig(ok_t);
    ok = ok_r && ok_t;
  endtask

  task automatic ack_and_settle();
    @(negedge clk);
    readyIn = ~readyIn;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({readyOut, triggerOut, condOut, classOut, opcodeOut, setFlagsOut, rnOut, rdOut, rmOut,
         immOut, linkOut, branchTargetOut, pcOut} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got ready=%b trig=%b cond=%h class=%h imm=%h pc=%h, want all 0",
               readyOut, triggerOut, condOut, classOut, immOut, pcOut);
    end
  endtask

  task automatic test_latency_dp_imm();
    @(posedge clk); #1;
    dataIn = 32'hE3A01005;
    pcIn = 32'h104;
    triggerIn = ~triggerIn;
    repeat (2) @(posedge clk); #1;
    compared++;
    if (readyOut !== exp_ready) begin
      mismatched++; $display("FAIL ready_early: got %b want %b at edge 2", readyOut, exp_ready);
    end
    @(posedge clk); #1;
    exp_ready = ~exp_ready;
    compared++;
    if (readyOut !== exp_ready) begin
      mismatched++; $display("FAIL ready_edge3: got %b want %b", readyOut, exp_ready);
    end
    @(posedge clk); #1;
    compared++;
    if (triggerOut !== exp_trig) begin
      mismatched++; $display("FAIL trig_early: got %b want %b at edge 4", triggerOut, exp_trig);
    end
    @(posedge clk); #1;
    exp_trig = ~exp_trig;
    compared++;
    if (triggerOut !== exp_trig) begin
      mismatched++; $display("FAIL trig_edge5: got %b want %b", triggerOut, exp_trig);
    end
    compared++;
    if ({condOut, classOut, opcodeOut, setFlagsOut, rnOut, rdOut, rmOut}
        !== {4'hE, 3'd1, 4'hD, 1'b0, 4'h0, 4'h1, 4'h5}) begin
      mismatched++;
      $display("FAIL mov_fields: got cond=%h class=%h op=%h s=%b rn=%h rd=%h rm=%h want E 1 D 0 0 1 5",
               condOut, classOut, opcodeOut, setFlagsOut, rnOut, rdOut, rmOut);
    end
    compared++;
    if (immOut !== 32'h5 || pcOut !== 32'h104) begin
      mismatched++; $display("FAIL mov_imm_pc: got imm=%h pc=%h want 00000005 00000104", immOut, pcOut);
    end
    ack_and_settle();
  endtask

  task automatic test_rotate();
    bit ok;
    send_and_decode(32'hE3A004FF, 32'h200, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL rot_handshake: got timeout want toggles"); end
    compared++;
    if (classOut !== 3'd1 || immOut !== 32'hFF000000) begin
      mismatched++; $display("FAIL rot_imm: got class=%h imm=%h want 1 FF000000", classOut, immOut);
    end
    ack_and_settle();
  endtask

  task automatic test_branch();
    bit ok;
    send_and_decode(32'hEAFFFFFE, 32'h104, ok);
    compared++;
    if (!ok || classOut !== 3'd3 || branchTargetOut !== 32'h100 || linkOut !== 1'b0) begin
      mismatched++;
      $display("FAIL b_back: got ok=%b class=%h tgt=%h link=%b want 1 3 00000100 0",
               ok, classOut, branchTargetOut, linkOut);
    end
    ack_and_settle();
    send_and_decode(32'hEB000002, 32'h200, ok);
    compared++;
    if (!ok || classOut !== 3'd3 || branchTargetOut !== 32'h20C || linkOut !== 1'b1 || opcodeOut !== 4'h0) begin
      mismatched++;
      $display("FAIL bl_fwd: got ok=%b class=%h tgt=%h link=%b op=%h want 1 3 0000020C 1 0",
               ok, classOut, branchTargetOut, linkOut, opcodeOut);
    end
    ack_and_settle();
  endtask

  task automatic test_ldst_mul();
    bit ok;
    send_and_decode(32'hE59F2010, 32'h300, ok);
    compared++;
    if (!ok || classOut !== 3'd2 || rnOut !== 4'hF || rdOut !== 4'h2 || immOut !== 32'h10) begin
      mismatched++;
      $display("FAIL ldr: got ok=%b class=%h rn=%h rd=%h imm=%h want 1 2 F 2 00000010",
               ok, classOut, rnOut, rdOut, immOut);
    end
    ack_and_settle();
    send_and_decode(32'hE0030291, 32'h304, ok);
    compared++;
    if (!ok || classOut !== 3'd4 || rdOut !== 4'h3 || rnOut !== 4'h2 || rmOut !== 4'h1
        || opcodeOut !== 4'h0 || immOut !== 32'h0) begin
      mismatched++;
      $display("FAIL mul: got ok=%b class=%h rd=%h rn=%h rm=%h op=%h imm=%h want 1 4 3 2 1 0 0",
               ok, classOut, rdOut, rnOut, rmOut, opcodeOut, immOut);
    end
    ack_and_settle();
  endtask

  task automatic test_other_classes();
    bit ok;
    send_and_decode(32'hE0912003, 32'h400, ok);
    compared++;
    if (!ok || classOut !== 3'd0 || opcodeOut !== 4'h4 || setFlagsOut !== 1'b1
        || rnOut !== 4'h1 || rdOut !== 4'h2 || rmOut !== 4'h3) begin
      mismatched++;
      $display("FAIL adds_reg: got ok=%b class=%h op=%h s=%b rn=%h rd=%h rm=%h want 1 0 4 1 1 2 3",
               ok, classOut, opcodeOut, setFlagsOut, rnOut, rdOut, rmOut);
    end
    ack_and_settle();
    send_and_decode(32'hEF123456, 32'h404, ok);
    compared++;
    if (!ok || classOut !== 3'd5 || immOut !== 32'h00123456) begin
      mismatched++; $display("FAIL swi: got ok=%b class=%h imm=%h want 1 5 00123456", ok, classOut, immOut);
    end
    ack_and_settle();
    send_and_decode(32'hAC123456, 32'h408, ok);
    compared++;
    if (!ok || condOut !== 4'hA || classOut !== 3'd7 || rnOut !== 4'h0 || rdOut !== 4'h0
        || immOut !== 32'h0 || setFlagsOut !== 1'b0) begin
      mismatched++;
      $display("FAIL undef: got ok=%b cond=%h class=%h rn=%h rd=%h imm=%h s=%b want 1 A 7 0 0 0 0",
               ok, condOut, classOut, rnOut, rdOut, immOut, setFlagsOut);
    end
    ack_and_settle();
  endtask

  task automatic test_back_to_back();
    bit ok;
    send_and_decode(32'hE3A01005, 32'h10, ok);
    put_word(32'hE59F2010, 32'h20);
    exp_ready = ~exp_ready;
    wait_ready(ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL b2b_second_accept: got timeout want readyOut=%b", exp_ready); end
    put_word(32'hEAFFFFFE, 32'h30);
    repeat (20) @(negedge clk);
    compared++;
    if (readyOut !== exp_ready || triggerOut !== exp_trig || pcOut !== 32'h10) begin
      mismatched++;
      $display("FAIL b2b_stall: got ready=%b trig=%b pc=%h want %b %b 00000010",
               readyOut, triggerOut, pcOut, exp_ready, exp_trig);
    end
    @(negedge clk);
    readyIn = ~readyIn;
    exp_trig = ~exp_trig;
    exp_ready = ~exp_ready;
    wait_trig(ok);
    compared++;
    if (!ok || readyOut !== exp_ready || classOut !== 3'd2 || pcOut !== 32'h20) begin
      mismatched++;
      $display("FAIL b2b_second_out: got ok=%b ready=%b class=%h pc=%h want 1 %b 2 00000020",
               ok, readyOut, classOut, pcOut, exp_ready);
    end
    @(negedge clk);
    readyIn = ~readyIn;
    exp_trig = ~exp_trig;
    wait_trig(ok);
    compared++;
    if (!ok || classOut !== 3'd3 || branchTargetOut !== 32'h2C || pcOut !== 32'h30) begin
      mismatched++;
      $display("FAIL b2b_third_out: got ok=%b class=%h tgt=%h pc=%h want 1 3 0000002C 00000030",
               ok, classOut, branchTargetOut, pcOut);
    end
    ack_and_settle();
  endtask

  task automatic test_reset_mid();
    bit ok;
    send_and_decode(32'hE0030291, 32'h60, ok);
    put_word(32'hE59F2010, 32'h64);
    exp_ready = ~exp_ready;
    wait_ready(ok);
    @(negedge clk);
    rst = 1'b1;
    triggerIn = 1'b0;
    readyIn = 1'b0;
    exp_ready = 1'b0;
    exp_trig = 1'b0;
    @(negedge clk);
    compared++;
    if ({readyOut, triggerOut, condOut, classOut, opcodeOut, setFlagsOut, rnOut, rdOut, rmOut,
         immOut, linkOut, branchTargetOut, pcOut} !== '0) begin
      mismatched++;
      $display("FAIL midreset_outputs: got ready=%b trig=%b class=%h rd=%h pc=%h, want all 0",
               readyOut, triggerOut, classOut, rdOut, pcOut);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    compared++;
    if (triggerOut !== 1'b0 || readyOut !== 1'b0) begin
      mismatched++; $display("FAIL midreset_no_replay: got ready=%b trig=%b want 0 0", readyOut, triggerOut);
    end
    send_and_decode(32'hE3A004FF, 32'h50, ok);
    compared++;
    if (!ok || classOut !== 3'd1 || immOut !== 32'hFF000000 || pcOut !== 32'h50) begin
      mismatched++;
      $display("FAIL midreset_fresh: got ok=%b class=%h imm=%h pc=%h want 1 1 FF000000 00000050",
               ok, classOut, immOut, pcOut);
    end
    ack_and_settle();
  endtask

  initial begin
    test_reset();
    test_latency_dp_imm();
    test_rotate();
    test_branch();
    test_ldst_mul();
    test_other_classes();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
